// File: rtl/mem_request_queue.sv
// Request queue: tags each accepted memory request with a sequential ID and buffers it in a FWFT FIFO.
// Optional sticky overflow/underflow monitoring is built when MEMQ_ERR_FLAGS_EN is defined.
module mem_request_queue #(
   parameter int DEPTH         = 8,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 31,
   parameter int TID_WIDTH     = 16,
   parameter int REQ_WIDTH     = 1 + ADDR_WIDTH + DATA_WIDTH,
   parameter int DP_DATA_WIDTH = TID_WIDTH + REQ_WIDTH,
   parameter int CNT_WIDTH     = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_rw,
   input  logic [ADDR_WIDTH-1:0]    req_addr,
   input  logic [DATA_WIDTH-1:0]    req_data,
   input  logic                     rd_en,
   output logic [DP_DATA_WIDTH-1:0] data_out,
   output logic                     empty,
   output logic                     full,
   output logic [CNT_WIDTH-1:0]     count,
   output logic [TID_WIDTH-1:0]     tid_next,
   output logic                     err_overflow,
   output logic                     err_underflow
);

   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
   localparam logic [TID_WIDTH-1:0] TID_ONE  = TID_WIDTH'(1);

   logic [DP_DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_WIDTH-1:0]     wr_ptr_r;
   logic [PTR_WIDTH-1:0]     rd_ptr_r;
   logic [CNT_WIDTH-1:0]     count_r;
   logic [CNT_WIDTH-1:0]     count_nxt_s;
   logic [TID_WIDTH-1:0]     tid_r;
   logic                     empty_r;
   logic                     full_r;
   logic [DP_DATA_WIDTH-1:0] hold_r;
   logic [REQ_WIDTH-1:0]     req_s;
   logic                     push_s;
   logic                     pop_s;

   // Handshakes are qualified only by registered flags, so full/empty never see req_valid/rd_en combinationally.
   assign push_s = req_valid && !full_r;
   assign pop_s  = rd_en && !empty_r;
   assign req_s  = {req_rw, req_addr, req_data};

   // Next occupancy from the qualified push/pop pair.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy, flags, ID counter and the last popped head.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {PTR_WIDTH{1'b0}};
         rd_ptr_r <= {PTR_WIDTH{1'b0}};
         count_r  <= CNT_ZERO;
         tid_r    <= {TID_WIDTH{1'b0}};
         empty_r  <= 1'b1;
         full_r   <= 1'b0;
         hold_r   <= {DP_DATA_WIDTH{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            tid_r    <= tid_r + TID_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            hold_r   <= mem_r[rd_ptr_r];
         end
         count_r <= count_nxt_s;
         empty_r <= (count_nxt_s == CNT_ZERO);
         full_r  <= (count_nxt_s == CNT_FULL);
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {tid_r, req_s};
      end
   end

   // While empty the head slot may be stale, so show the last popped entry (0 after reset).
   assign data_out  = empty_r ? hold_r : mem_r[rd_ptr_r];
   assign empty     = empty_r;
   assign full      = full_r;
   assign req_ready = !full_r;
   assign count     = count_r;
   assign tid_next  = tid_r;

`ifdef MEMQ_ERR_FLAGS_EN
   logic ovf_r;
   logic unf_r;

   // Sticky illegal-access monitors, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_r <= 1'b0;
         unf_r <= 1'b0;
      end else begin
         if (req_valid && full_r) begin
            ovf_r <= 1'b1;
            $display("%m: push attempted while full, tid_next=%0d", tid_r);
         end
         if (rd_en && empty_r) begin
            unf_r <= 1'b1;
            $display("%m: pop attempted while empty, tid_next=%0d", tid_r);
         end
      end
   end

   assign err_overflow  = ovf_r;
   assign err_underflow = unf_r;
`else
   assign err_overflow  = 1'b0;
   assign err_underflow = 1'b0;
`endif

endmodule
